// File: rtl/norm_shift_ctrl.sv
// Multi-cycle FP mantissa normalizer: left-shifts up to MAX_STEP bits per cycle
// until the MSB is set or the exponent reaches 1, with valid/ready on both sides.

module SHF_unit #(
   parameter int unsigned LEFT_RIGHT = 0,
   parameter int unsigned SIZE_DATA  = 24,
   parameter int unsigned SIZE_SHIFT = 5
) (
   input  logic [SIZE_DATA-1:0]  i_data,
   input  logic [SIZE_SHIFT-1:0] i_shift,
   output logic [SIZE_DATA-1:0]  o_data
);
   generate
      if (LEFT_RIGHT == 0) begin : g_left
         assign o_data = i_data << i_shift;
      end else begin : g_right
         assign o_data = i_data >> i_shift;
      end
   endgenerate
endmodule

module norm_shift_ctrl #(
   parameter int unsigned SIZE_DATA  = 24,
   parameter int unsigned SIZE_EXP   = 8,
   parameter int unsigned SIZE_SHIFT = 5,
   parameter int unsigned MAX_STEP   = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [SIZE_DATA-1:0]  i_mant,
   input  logic [SIZE_EXP-1:0]   i_exp,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [SIZE_DATA-1:0]  o_mant,
   output logic [SIZE_EXP-1:0]   o_exp,
   output logic [SIZE_SHIFT-1:0] o_shift_total,
   output logic                  o_zero,
   output logic                  o_denorm
);

   // Compare width wide enough for both the exponent and the shift amount
   localparam int unsigned CW = ((SIZE_EXP > SIZE_SHIFT) ? SIZE_EXP : SIZE_SHIFT) + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]            state_q,  state_d;
   logic [SIZE_DATA-1:0]  mant_q,   mant_d;
   logic [SIZE_EXP-1:0]   exp_q,    exp_d;
   logic [SIZE_SHIFT-1:0] total_q,  total_d;
   logic                  zero_q,   zero_d;
   logic                  denorm_q, denorm_d;

   logic [SIZE_SHIFT-1:0] lz;
   logic                  lz_found;
   logic [CW-1:0]         limit, need, step_w;
   logic [SIZE_SHIFT-1:0] step;
   logic [SIZE_DATA-1:0]  shf_out;

   // Leading-zero count of the working mantissa
   always_comb begin
      lz       = '0;
      lz_found = 1'b0;
      for (int i = int'(SIZE_DATA) - 1; i >= 0; i--) begin
         if (!lz_found) begin
            if (mant_q[i]) lz_found = 1'b1;
            else           lz = lz + SIZE_SHIFT'(1);
         end
      end
   end

   // Shift needed is bounded by the exponent floor of 1, then by the per-cycle cap
   always_comb begin
      limit  = CW'(exp_q) - CW'(1);
      need   = (CW'(lz) < limit) ? CW'(lz) : limit;
      step_w = (need > CW'(MAX_STEP)) ? CW'(MAX_STEP) : need;
      step   = SIZE_SHIFT'(step_w);
   end

   SHF_unit #(
      .LEFT_RIGHT (0),
      .SIZE_DATA  (SIZE_DATA),
      .SIZE_SHIFT (SIZE_SHIFT)
   ) u_shf (
      .i_data  (mant_q),
      .i_shift (step),
      .o_data  (shf_out)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         mant_q   <= '0;
         exp_q    <= '0;
         total_q  <= '0;
         zero_q   <= 1'b0;
         denorm_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         mant_q   <= mant_d;
         exp_q    <= exp_d;
         total_q  <= total_d;
         zero_q   <= zero_d;
         denorm_q <= denorm_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mant_d   = mant_q;
      exp_d    = exp_q;
      total_d  = total_q;
      zero_d   = zero_q;
      denorm_d = denorm_q;
      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               mant_d   = i_mant;
               exp_d    = i_exp;
               total_d  = '0;
               zero_d   = 1'b0;
               denorm_d = 1'b0;
               if (i_mant == '0) begin
                  exp_d   = '0;
                  zero_d  = 1'b1;
                  state_d = ST_DONE;
               end else if (i_exp == '0) begin
                  denorm_d = ~i_mant[SIZE_DATA-1];
                  state_d  = ST_DONE;
               end else begin
                  state_d = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            mant_d  = shf_out;
            exp_d   = exp_q - SIZE_EXP'(step_w);
            total_d = total_q + step;
            if (step_w == need) begin
               denorm_d = ~shf_out[SIZE_DATA-1];
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (i_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign o_ready       = (state_q == ST_IDLE);
   assign o_valid       = (state_q == ST_DONE);
   assign o_mant        = mant_q;
   assign o_exp         = exp_q;
   assign o_shift_total = total_q;
   assign o_zero        = zero_q;
   assign o_denorm      = denorm_q;

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Directed and randomized checks of norm_shift_ctrl against a shift-to-normalize model.

module tb_norm_shift_ctrl;

   localparam int unsigned SD = 24;
   localparam int unsigned SE = 8;
   localparam int unsigned SS = 5;
   localparam int unsigned MS = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          out_ready;
   logic [SD-1:0] in_mant;
   logic [SE-1:0] in_exp;
   logic          out_valid;
   logic          in_ready;
   logic [SD-1:0] out_mant;
   logic [SE-1:0] out_exp;
   logic [SS-1:0] out_total;
   logic          out_zero;
   logic          out_denorm;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   norm_shift_ctrl #(
      .SIZE_DATA (SD), .SIZE_EXP (SE), .SIZE_SHIFT (SS), .MAX_STEP (MS)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_valid       (in_valid),
      .o_ready       (out_ready),
      .i_mant        (in_mant),
      .i_exp         (in_exp),
      .o_valid       (out_valid),
      .i_ready       (in_ready),
      .o_mant        (out_mant),
      .o_exp         (out_exp),
      .o_shift_total (out_total),
      .o_zero        (out_zero),
      .o_denorm      (out_denorm)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Normalize in one go: shift by leading zeros, floored so the exponent stays >= 1
   task automatic model(input logic [SD-1:0] m, input logic [SE-1:0] e,
                        output logic [SD-1:0] rm, output logic [SE-1:0] re,
                        output int rt, output logic rz, output logic rd, output int lat);
      int lz, need, n;
      if (m == 0) begin
         rm = '0; re = '0; rt = 0; rz = 1'b1; rd = 1'b0; lat = 1;
      end else if (e == 0) begin
         rm = m; re = '0; rt = 0; rz = 1'b0; rd = ~m[SD-1]; lat = 1;
      end else begin
         lz = 0;
         while (m[SD-1-lz] == 1'b0) lz++;
         need = (lz < int'(e) - 1) ? lz : int'(e) - 1;
         rm   = m << need;
         re   = SE'(int'(e) - need);
         rt   = need;
         rz   = 1'b0;
         rd   = ~rm[SD-1];
         n    = (need + int'(MS) - 1) / int'(MS);
         if (n == 0) n = 1;
         lat  = 1 + n;
      end
   endtask

   task automatic run_op(input string tag, input logic [SD-1:0] m, input logic [SE-1:0] e,
                         input int hold);
      logic [SD-1:0] rm;
      logic [SE-1:0] re;
      int rt, lat, cnt;
      logic rz, rd;
      model(m, e, rm, re, rt, rz, rd, lat);
      cnt = 0;
      while (!out_ready && cnt < 64) begin tick(); cnt++; end
      check({tag, ".ready_in"}, 32'(out_ready), 32'd1);
      in_ready = (hold == 0);
      in_mant  = m;
      in_exp   = e;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cnt = 1;
      while (!out_valid && cnt < 64) begin tick(); cnt++; end
      check({tag, ".latency"}, 32'(cnt), 32'(lat));
      check({tag, ".mant"},   32'(out_mant),   32'(rm));
      check({tag, ".exp"},    32'(out_exp),    32'(re));
      check({tag, ".total"},  32'(out_total),  32'(rt));
      check({tag, ".zero"},   32'(out_zero),   32'(rz));
      check({tag, ".denorm"}, 32'(out_denorm), 32'(rd));
      check({tag, ".busy"},   32'(out_ready),  32'd0);
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, ".hold_mant"},  32'(out_mant),  32'(rm));
         check({tag, ".hold_exp"},   32'(out_exp),   32'(re));
         check({tag, ".hold_ready"}, 32'(out_ready), 32'd0);
      end
      in_ready = 1'b1;
      tick();
      check({tag, ".post_valid"}, 32'(out_valid), 32'd0);
      check({tag, ".post_ready"}, 32'(out_ready), 32'd1);
   endtask

   initial begin
      logic [SD-1:0] m;
      logic [SE-1:0] e;
      rst = 1'b1; in_valid = 1'b1; in_mant = 24'h000123; in_exp = 8'd9; in_ready = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      rst = 1'b0;
      check("rst.ready",  32'(out_ready),  32'd1);
      check("rst.valid",  32'(out_valid),  32'd0);
      check("rst.mant",   32'(out_mant),   32'd0);
      check("rst.exp",    32'(out_exp),    32'd0);
      check("rst.total",  32'(out_total),  32'd0);
      check("rst.zero",   32'(out_zero),   32'd0);
      check("rst.denorm", 32'(out_denorm), 32'd0);

      // Abort mid-shift: no result may appear afterwards
      in_mant = 24'h000001; in_exp = 8'd100; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("abort.in_shift", 32'(out_ready), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort.ready", 32'(out_ready), 32'd1);
      check("abort.valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("abort.no_valid", 32'(out_valid), 32'd0);
      end

      run_op("full23",  24'h000001, 8'd100, 0);
      run_op("noop",    24'h800000, 8'd10,  0);
      run_op("clamp",   24'h000100, 8'd5,   0);
      run_op("zero",    24'h000000, 8'd50,  0);
      run_op("exp0",    24'h000F00, 8'd0,   0);
      run_op("exp0msb", 24'h812345, 8'd0,   0);
      run_op("exp1",    24'h000040, 8'd1,   0);
      run_op("step8",   24'h008000, 8'd200, 0);
      run_op("bp",      24'h000001, 8'd100, 5);

      for (int k = 0; k < 500; k++) begin
         m = SD'($urandom) >> $urandom_range(0, SD);
         if ($urandom_range(0, 19) == 0) m = '0;
         e = ($urandom_range(0, 1) == 0) ? SE'($urandom_range(0, 12)) : SE'($urandom);
         run_op("rand", m, e, int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
